// File: rtl/uart_tx_pkg.sv
// Shared types and line levels for the UART transmit serializer.
// The PARITY state is always declared so its encoding does not move when UART_TX_PARITY_EN is set.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/flex_pts_sr.sv
// Parallel-to-serial shift register. Reset and shift fill are all ones; load wins over shift.
// SHIFT_MSB=0 shifts out LSB first, SHIFT_MSB=1 shifts out MSB first.
module flex_pts_sr #(
    parameter int unsigned NUM_BITS  = 8,
    parameter bit          SHIFT_MSB = 1'b0
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                load_enable,
    input  logic                shift_enable,
    input  logic [NUM_BITS-1:0] parallel_in,
    output logic                serial_out
);

    logic [NUM_BITS-1:0] sr_q, sr_d, sr_shifted;

    generate
        if (SHIFT_MSB) begin : g_msb
            assign sr_shifted = {sr_q[NUM_BITS-2:0], 1'b1};
            assign serial_out = sr_q[NUM_BITS-1];
        end else begin : g_lsb
            assign sr_shifted = {1'b1, sr_q[NUM_BITS-1:1]};
            assign serial_out = sr_q[0];
        end
    endgenerate

    always_comb begin
        sr_d = sr_q;
        if (load_enable) begin
            sr_d = parallel_in;
        end else if (shift_enable) begin
            sr_d = sr_shifted;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sr_q <= '1;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: frames a parallel byte as start, LSB-first data, [parity], stop.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_start,
    output logic                 tx_ready,
    output logic                 serial_out,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic             serial_out_q, serial_out_d;
    logic             tx_ready_q, tx_ready_d;
    logic             tx_busy_q, tx_busy_d;
    logic             tx_done_q, tx_done_d;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic load_en, shift_en, sr_out, bit_end;

    flex_pts_sr #(
        .NUM_BITS  (DATA_BITS),
        .SHIFT_MSB (1'b0)
    ) u_sr (
        .clk          (clk),
        .n_rst        (n_rst),
        .load_enable  (load_en),
        .shift_enable (shift_en),
        .parallel_in  (tx_data),
        .serial_out   (sr_out)
    );

    assign bit_end = (cnt_q == CNT_MAX);

    // The register shifts as each bit is copied to the line, so sr_out is always the next bit.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        serial_out_d = serial_out_q;
        tx_done_d    = 1'b0;
        load_en      = 1'b0;
        shift_en     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d     = parity_q;
`endif
        case (state_q)
            IDLE: begin
                serial_out_d = IDLE_LEVEL;
                if (tx_start && tx_ready_q) begin
                    load_en      = 1'b1;
                    state_d      = START;
                    cnt_d        = '0;
                    serial_out_d = START_LEVEL;
`ifdef UART_TX_PARITY_EN
                    parity_d     = ^tx_data;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d        = '0;
                    bit_idx_d    = '0;
                    state_d      = DATA;
                    serial_out_d = sr_out;
                    shift_en     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d      = PARITY;
                        serial_out_d = parity_q;
`else
                        state_d      = STOP;
                        serial_out_d = STOP_LEVEL;
`endif
                    end else begin
                        bit_idx_d    = bit_idx_q + IDX_ONE;
                        serial_out_d = sr_out;
                        shift_en     = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    cnt_d        = '0;
                    state_d      = STOP;
                    serial_out_d = STOP_LEVEL;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    cnt_d        = '0;
                    state_d      = IDLE;
                    serial_out_d = IDLE_LEVEL;
                    tx_done_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d      = IDLE;
                cnt_d        = '0;
                serial_out_d = IDLE_LEVEL;
            end
        endcase
        tx_ready_d = (state_d == IDLE);
        tx_busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            serial_out_q <= IDLE_LEVEL;
            tx_ready_q   <= 1'b1;
            tx_busy_q    <= 1'b0;
            tx_done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            serial_out_q <= serial_out_d;
            tx_ready_q   <= tx_ready_d;
            tx_busy_q    <= tx_busy_d;
            tx_done_q    <= tx_done_d;
`ifdef UART_TX_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    assign serial_out = serial_out_q;
    assign tx_ready   = tx_ready_q;
    assign tx_busy    = tx_busy_q;
    assign tx_done    = tx_done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: a frame-level model queues expected characters
// and their acceptance cycle; an independent line monitor decodes and checks them.
module tb_uart_tx_serializer;

    localparam int D = 8;
    localparam int C = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NB = D + 3;
`else
    localparam int NB = D + 2;
`endif
    localparam int FRAME = NB * C;

    typedef struct {
        int          acc_cyc;
        logic [15:0] bits;
    } exp_t;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic [D-1:0] tx_data = '0;
    logic         tx_start = 1'b0;
    logic         tx_ready, serial_out, tx_busy, tx_done;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   free_edge = 0;
    int   n_acc = 0;
    exp_t exp_q[$];
    logic mon_en = 1'b0;
    logic mon_busy = 1'b0;

    always #5 clk = ~clk;

    uart_tx_serializer #(
        .DATA_BITS    (D),
        .CLKS_PER_BIT (C)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_ready   (tx_ready),
        .serial_out (serial_out),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Character as it should appear on the line, index 0 sent first.
    function automatic logic [15:0] frame_of(input logic [D-1:0] d);
        logic [15:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < D; i++) f[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
        f[D+1] = ^d;
`endif
        f[NB-1] = 1'b1;
        return f;
    endfunction

    // Reference model: a byte is taken whenever start is high and the previous frame
    // plus its done cycle have elapsed.
    initial begin
        forever begin
            @(posedge clk);
            if (!n_rst) begin
                exp_q.delete();
                free_edge = 0;
            end else if (tx_start && cyc >= free_edge) begin
                exp_q.push_back('{acc_cyc: cyc, bits: frame_of(tx_data)});
                free_edge = cyc + FRAME + 1;
                n_acc++;
            end
            cyc++;
        end
    end

    // Line monitor
    initial begin
        logic have_start;
        exp_t e;
        have_start = 1'b0;
        wait (mon_en);
        forever begin
            if (!have_start) begin
                @(negedge clk);
                have_start = (serial_out === 1'b0);
            end
            if (have_start) begin
                mon_busy = 1'b1;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_frame: got start bit expected idle line (cycle %0d)",
                             cyc);
                    e = '{acc_cyc: cyc - 1, bits: 16'hFFFF};
                end else begin
                    e = exp_q.pop_front();
                end
                check_int("start_latency", cyc - 1, e.acc_cyc);
                for (int j = 1; j <= FRAME; j++) begin
                    @(negedge clk);
                    if (j % C == C / 2) begin
                        check($sformatf("bit%0d", j / C), serial_out, e.bits[j/C]);
                        check("busy_in_frame", tx_busy, 1'b1);
                        check("ready_in_frame", tx_ready, 1'b0);
                        check("done_in_frame", tx_done, 1'b0);
                    end
                    if (j == FRAME - 1) check("done_early", tx_done, 1'b0);
                    if (j == FRAME) begin
                        check("done_pulse", tx_done, 1'b1);
                        check("ready_after", tx_ready, 1'b1);
                        check("busy_after", tx_busy, 1'b0);
                        check("line_after", serial_out, 1'b1);
                    end
                end
                @(negedge clk);
                check("done_width", tx_done, 1'b0);
                have_start = (serial_out === 1'b0);
                mon_busy = have_start;
            end
        end
    end

    task automatic wait_free();
        int n;
        n = 0;
        while (cyc < free_edge && n < 4 * FRAME) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic wait_acc(input int target);
        int n;
        n = 0;
        while (n_acc < target && n < 4 * FRAME) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_int("accept_count", n_acc, target);
    endtask

    task automatic send(input logic [D-1:0] d);
        wait_free();
        tx_data  = d;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
    endtask

    initial begin
        int   n;
        int   base;
        logic hold;

        // Reset state and mid-frame reset
        repeat (3) @(posedge clk);
        #1 n_rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_line", serial_out, 1'b1);
        check("rst_ready", tx_ready, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_done", tx_done, 1'b0);
        send(8'hA5);
        repeat (3) @(posedge clk);
        #1;
        check("start_level", serial_out, 1'b0);
        n_rst = 1'b0;
        #1;
        check("midrst_line", serial_out, 1'b1);
        check("midrst_ready", tx_ready, 1'b1);
        check("midrst_busy", tx_busy, 1'b0);
        check("midrst_done", tx_done, 1'b0);
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        for (int i = 0; i < 2 * C; i++) begin
            @(posedge clk);
            #1;
            check("postrst_line", serial_out, 1'b1);
            check("postrst_done", tx_done, 1'b0);
        end
        mon_en = 1'b1;

        // Single frame, then a start pulse that must be ignored mid-frame
        send(8'hA5);
        repeat (34) @(posedge clk);
        #1;
        tx_data  = 8'h3C;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        check("busy_ready", tx_ready, 1'b0);

        // Back-to-back with start held high
        wait_free();
        base     = n_acc;
        tx_data  = 8'h00;
        tx_start = 1'b1;
        wait_acc(base + 1);
        tx_data = 8'hFF;
        wait_acc(base + 2);
        tx_start = 1'b0;

        // Data changed one clock after acceptance
        wait_free();
        tx_data  = 8'h0F;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        tx_data  = 8'hF0;
        send(8'h07);

        // Random traffic: sparse pulses and held-start stretches with churning data
        wait_free();
        hold = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            @(posedge clk);
            #1;
            if (i % 250 == 0) hold = ($urandom_range(0, 2) == 0);
            tx_start = hold ? 1'b1 : ($urandom_range(0, 19) == 0);
            tx_data  = D'($urandom);
        end
        tx_start = 1'b0;

        n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < 3 * FRAME) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_cmp++;
        if (exp_q.size() != 0 || mon_busy) begin
            n_fail++;
            $display("FAIL drain: %0d frames pending, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
